// File: rtl/arb_requester.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : arb_requester                                                |
// | Description : Client side of the 2-way req/gnt arbiter handshake. Queues   |
// |               transfer commands, requests the bus, emits one beat per      |
// |               granted cycle, then releases and waits out a re-request gap. |
// |               Optional REQ watchdog: define ARB_REQ_WATCHDOG_EN.           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module arb_requester #(
  parameter int LEN_W       = 8,
  parameter int DEPTH       = 4,
  parameter int GAP         = 2,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_valid,
  input  logic [LEN_W-1:0] cmd_len,
  output logic             cmd_ready,
  output logic             req,
  input  logic             gnt,
  output logic             beat_valid,
  output logic             beat_last,
  output logic [LEN_W-1:0] beat_cnt,
  output logic             done,
  output logic             busy
`ifdef ARB_REQ_WATCHDOG_EN
  ,
  output logic             timeout
`endif
);

  localparam int PTR_W = (DEPTH < 2) ? 1 : $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int GAP_W = (GAP < 1) ? 1 : $clog2(GAP + 1);
`ifdef ARB_REQ_WATCHDOG_EN
  localparam int WD_W  = (TIMEOUT_CYC < 1) ? 1 : $clog2(TIMEOUT_CYC + 1);
`endif

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_XFER    = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  // Command FIFO
  logic [LEN_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;
  logic [LEN_W-1:0] w_head;

  // Control state and registered outputs
  state_t           r_state,    w_state_n;
  logic             r_req,      w_req_n;
  logic             r_bv,       w_bv_n;
  logic             r_bl,       w_bl_n;
  logic [LEN_W-1:0] r_beat_cnt, w_bc_n;
  logic             r_done,     w_done_n;
  logic [LEN_W-1:0] r_rem,      w_rem_n;
  logic [LEN_W-1:0] r_idx,      w_idx_n;
  logic [GAP_W-1:0] r_gap,      w_gap_n;
`ifdef ARB_REQ_WATCHDOG_EN
  logic [WD_W-1:0]  r_wd,       w_wd_n;
  logic             r_to,       w_to_n;
`endif

  assign cmd_ready  = (r_count != CNT_W'(DEPTH));
  assign w_push     = cmd_valid & cmd_ready;
  assign w_head     = r_mem[r_rd_ptr];

  assign req        = r_req;
  assign beat_valid = r_bv;
  assign beat_last  = r_bl;
  assign beat_cnt   = r_beat_cnt;
  assign done       = r_done;
  assign busy       = (r_count != '0) | (r_state != S_IDLE) | (r_gap != '0);
`ifdef ARB_REQ_WATCHDOG_EN
  assign timeout    = r_to;
`endif

  // FIFO storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr_ptr] <= cmd_len;
  end

  // FIFO pointers and occupancy; a simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Next-state and next-output decode; outputs are registered so req, beat and done move together.
  always_comb begin
    w_state_n = r_state;
    w_req_n   = r_req;
    w_bv_n    = 1'b0;
    w_bl_n    = 1'b0;
    w_bc_n    = r_beat_cnt;
    w_done_n  = 1'b0;
    w_rem_n   = r_rem;
    w_idx_n   = r_idx;
    w_gap_n   = r_gap;
    w_pop     = 1'b0;
`ifdef ARB_REQ_WATCHDOG_EN
    w_wd_n    = r_wd;
    w_to_n    = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (r_gap != '0) begin
          w_gap_n = r_gap - GAP_W'(1);
        end else if (r_count != '0) begin
          w_pop = 1'b1;
          if (w_head == '0) begin
            // Null command completes without touching the arbiter.
            w_done_n = 1'b1;
          end else begin
            w_req_n   = 1'b1;
            w_rem_n   = w_head;
            w_idx_n   = '0;
            w_bc_n    = '0;
            w_state_n = S_REQ;
`ifdef ARB_REQ_WATCHDOG_EN
            w_wd_n    = '0;
`endif
          end
        end
      end
      S_REQ: begin
        if (gnt) begin
          w_state_n = S_XFER;
        end
`ifdef ARB_REQ_WATCHDOG_EN
        else if (r_wd == WD_W'(TIMEOUT_CYC - 1)) begin
          // Grant never came: abandon the command and release the bus.
          w_req_n   = 1'b0;
          w_to_n    = 1'b1;
          w_done_n  = 1'b1;
          w_state_n = S_RELEASE;
        end else begin
          w_wd_n = r_wd + WD_W'(1);
        end
`endif
      end
      S_XFER: begin
        if (gnt) begin
          w_bv_n  = 1'b1;
          w_bc_n  = r_idx;
          w_idx_n = r_idx + LEN_W'(1);
          w_rem_n = r_rem - LEN_W'(1);
          if (r_rem == LEN_W'(1)) begin
            w_bl_n    = 1'b1;
            w_done_n  = 1'b1;
            w_req_n   = 1'b0;
            w_state_n = S_RELEASE;
          end
        end
      end
      S_RELEASE: begin
        // The arbiter may keep gnt high briefly; wait for it to clear.
        if (!gnt) begin
          w_gap_n   = GAP_W'(GAP);
          w_state_n = S_IDLE;
        end
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_req      <= 1'b0;
      r_bv       <= 1'b0;
      r_bl       <= 1'b0;
      r_beat_cnt <= '0;
      r_done     <= 1'b0;
      r_rem      <= '0;
      r_idx      <= '0;
      r_gap      <= '0;
`ifdef ARB_REQ_WATCHDOG_EN
      r_wd       <= '0;
      r_to       <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_n;
      r_req      <= w_req_n;
      r_bv       <= w_bv_n;
      r_bl       <= w_bl_n;
      r_beat_cnt <= w_bc_n;
      r_done     <= w_done_n;
      r_rem      <= w_rem_n;
      r_idx      <= w_idx_n;
      r_gap      <= w_gap_n;
`ifdef ARB_REQ_WATCHDOG_EN
      r_wd       <= w_wd_n;
      r_to       <= w_to_n;
`endif
    end
  end

endmodule
`default_nettype wire
